// File: rtl/dmi_responder.sv
// Debug-module end of the DMI request/response channel: a small register file
// (data0, dmcontrol, dmstatus, abstractcs, command) plus an abstract-command launcher.
module dmi_responder #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  debug_req_valid,
  output logic                  debug_req_ready,
  input  logic [6:0]            debug_req_bits_addr,
  input  logic [1:0]            debug_req_bits_op,
  input  logic [DATA_WIDTH-1:0] debug_req_bits_data,
  output logic                  debug_resp_valid,
  input  logic                  debug_resp_ready,
  output logic [1:0]            debug_resp_bits_resp,
  output logic [DATA_WIDTH-1:0] debug_resp_bits_data,
  output logic                  dmactive,
  output logic                  ndmreset,
  output logic                  haltreq,
  output logic                  cmd_start,
  output logic [15:0]           cmd_regno,
  output logic                  cmd_write,
  output logic [31:0]           cmd_wdata,
  input  logic                  cmd_done,
  input  logic [31:0]           cmd_rdata
);

  localparam logic [6:0] ADDR_DATA0      = 7'h04;
  localparam logic [6:0] ADDR_DMCONTROL  = 7'h10;
  localparam logic [6:0] ADDR_DMSTATUS   = 7'h11;
  localparam logic [6:0] ADDR_ABSTRACTCS = 7'h16;
  localparam logic [6:0] ADDR_COMMAND    = 7'h17;

  localparam logic [1:0] OP_NOP   = 2'd0;
  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_WRITE = 2'd2;
  localparam logic [1:0] OP_RSVD  = 2'd3;

  localparam logic [2:0] CMDERR_BUSY      = 3'd1;
  localparam logic [2:0] CMDERR_NOTSUP    = 3'd2;
  localparam logic [31:0] DMSTATUS_VALUE  = 32'h0000_0082;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_t;

  state_t                  state_reg;
  logic                    req_ready_reg;
  logic                    resp_valid_reg;
  logic [1:0]              resp_code_reg;
  logic [DATA_WIDTH-1:0]   resp_data_reg;

  logic                    dmactive_reg;
  logic                    ndmreset_reg;
  logic                    haltreq_reg;
  logic [31:0]             data0_reg;
  logic [2:0]              cmderr_reg;
  logic                    busy_reg;
  logic                    cmd_start_reg;
  logic [15:0]             cmd_regno_reg;
  logic                    cmd_write_reg;
  logic [31:0]             cmd_wdata_reg;

  logic                    req_fire;
  logic                    is_read;
  logic                    is_write;
  logic [31:0]             wdata32;
  logic                    data0_access;
  logic                    data0_wr;
  logic                    dmcontrol_wr;
  logic                    abstractcs_wr;
  logic                    command_wr;
  logic                    cmd_eval;
  logic                    cmd_busy_err;
  logic                    cmd_notsup_err;
  logic                    cmd_go;
  logic                    busy_err;
  logic                    done_fire;
  logic [31:0]             rd32;
  logic [DATA_WIDTH-1:0]   rdata_ext;

  assign req_fire      = debug_req_valid & req_ready_reg;
  assign is_read       = (debug_req_bits_op == OP_READ);
  assign is_write      = (debug_req_bits_op == OP_WRITE);
  assign wdata32       = debug_req_bits_data[31:0];

  assign data0_access  = req_fire & (is_read | is_write) & (debug_req_bits_addr == ADDR_DATA0);
  assign data0_wr      = data0_access & is_write;
  assign dmcontrol_wr  = req_fire & is_write & (debug_req_bits_addr == ADDR_DMCONTROL);
  assign abstractcs_wr = req_fire & is_write & (debug_req_bits_addr == ADDR_ABSTRACTCS);
  assign command_wr    = req_fire & is_write & (debug_req_bits_addr == ADDR_COMMAND);

  // Command acceptance cascade: inactive DM, busy, sticky error, unsupported, transfer.
  assign cmd_eval       = command_wr & dmactive_reg;
  assign cmd_busy_err   = cmd_eval & busy_reg;
  assign cmd_notsup_err = cmd_eval & ~busy_reg & (cmderr_reg == 3'd0) & (wdata32[31:24] != 8'd0);
  assign cmd_go         = cmd_eval & ~busy_reg & (cmderr_reg == 3'd0) & (wdata32[31:24] == 8'd0)
                          & wdata32[17];

  assign busy_err  = (data0_access & busy_reg) | cmd_busy_err;
  assign done_fire = cmd_done & busy_reg;

  always_comb begin
    rd32 = 32'd0;
    case (debug_req_bits_addr)
      ADDR_DATA0:      rd32 = data0_reg;
      ADDR_DMCONTROL:  rd32 = {haltreq_reg, 29'd0, ndmreset_reg, dmactive_reg};
      ADDR_DMSTATUS:   rd32 = DMSTATUS_VALUE;
      ADDR_ABSTRACTCS: rd32 = {19'd0, busy_reg, 1'b0, cmderr_reg, 4'd0, 4'd1};
      default:         rd32 = 32'd0;
    endcase
  end

  // Registers live in the low word; the rest of the DMI data path reads as zero.
  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_rd_low
      assign rdata_ext[gi] = rd32[gi];
    end
    for (gi = 32; gi < DATA_WIDTH; gi++) begin : g_rd_high
      assign rdata_ext[gi] = 1'b0;
    end
    if (DATA_WIDTH > 32) begin : g_wr_high
      logic unused_wdata_high;
      assign unused_wdata_high = ^debug_req_bits_data[DATA_WIDTH-1:32];
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= ST_IDLE;
      req_ready_reg  <= 1'b1;
      resp_valid_reg <= 1'b0;
      resp_code_reg  <= 2'd0;
      resp_data_reg  <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (req_fire) begin
            state_reg      <= ST_RESP;
            req_ready_reg  <= 1'b0;
            resp_valid_reg <= 1'b1;
            resp_code_reg  <= (debug_req_bits_op == OP_RSVD) ? 2'd2 : 2'd0;
            resp_data_reg  <= is_read ? rdata_ext : '0;
          end
        end
        ST_RESP: begin
          if (debug_resp_ready) begin
            state_reg      <= ST_IDLE;
            req_ready_reg  <= 1'b1;
            resp_valid_reg <= 1'b0;
          end
        end
        default: begin
          state_reg      <= ST_IDLE;
          req_ready_reg  <= 1'b1;
          resp_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dmactive_reg  <= 1'b0;
      ndmreset_reg  <= 1'b0;
      haltreq_reg   <= 1'b0;
      data0_reg     <= 32'd0;
      cmderr_reg    <= 3'd0;
      busy_reg      <= 1'b0;
      cmd_start_reg <= 1'b0;
      cmd_regno_reg <= 16'd0;
      cmd_write_reg <= 1'b0;
      cmd_wdata_reg <= 32'd0;
    end else begin
      cmd_start_reg <= cmd_go;

      if (data0_wr && !busy_reg) begin
        data0_reg <= wdata32;
      end

      if (dmcontrol_wr) begin
        dmactive_reg <= wdata32[0];
        if (wdata32[0]) begin
          ndmreset_reg <= wdata32[1];
          haltreq_reg  <= wdata32[31];
        end else begin
          ndmreset_reg <= 1'b0;
          haltreq_reg  <= 1'b0;
          data0_reg    <= 32'd0;
          cmderr_reg   <= 3'd0;
        end
      end

      if (abstractcs_wr) begin
        cmderr_reg <= cmderr_reg & ~wdata32[10:8];
      end

      if (busy_err && (cmderr_reg == 3'd0)) begin
        cmderr_reg <= CMDERR_BUSY;
      end

      if (cmd_notsup_err) begin
        cmderr_reg <= CMDERR_NOTSUP;
      end

      if (cmd_go) begin
        busy_reg      <= 1'b1;
        cmd_regno_reg <= wdata32[15:0];
        cmd_write_reg <= wdata32[16];
        cmd_wdata_reg <= data0_reg;
      end

      // Completion is written last so its data0 update wins any same-edge collision.
      if (done_fire) begin
        busy_reg <= 1'b0;
        if (!cmd_write_reg) begin
          data0_reg <= cmd_rdata;
        end
      end
    end
  end

  assign debug_req_ready      = req_ready_reg;
  assign debug_resp_valid     = resp_valid_reg;
  assign debug_resp_bits_resp = resp_code_reg;
  assign debug_resp_bits_data = resp_data_reg;
  assign dmactive             = dmactive_reg;
  assign ndmreset             = ndmreset_reg;
  assign haltreq              = haltreq_reg;
  assign cmd_start            = cmd_start_reg;
  assign cmd_regno            = cmd_regno_reg;
  assign cmd_write            = cmd_write_reg;
  assign cmd_wdata            = cmd_wdata_reg;

endmodule

// File: tb/tb_dmi_responder.sv
// Directed bench for dmi_responder: register-map vector table followed by
// hand-written abstract-command, back-pressure and reset sequences.
module tb_dmi_responder;

  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          debug_req_valid;
  logic          debug_req_ready;
  logic [6:0]    debug_req_bits_addr;
  logic [1:0]    debug_req_bits_op;
  logic [DW-1:0] debug_req_bits_data;
  logic          debug_resp_valid;
  logic          debug_resp_ready;
  logic [1:0]    debug_resp_bits_resp;
  logic [DW-1:0] debug_resp_bits_data;
  logic          dmactive;
  logic          ndmreset;
  logic          haltreq;
  logic          cmd_start;
  logic [15:0]   cmd_regno;
  logic          cmd_write;
  logic [31:0]   cmd_wdata;
  logic          cmd_done;
  logic [31:0]   cmd_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dmi_responder #(.DATA_WIDTH(DW)) dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .debug_req_valid      (debug_req_valid),
    .debug_req_ready      (debug_req_ready),
    .debug_req_bits_addr  (debug_req_bits_addr),
    .debug_req_bits_op    (debug_req_bits_op),
    .debug_req_bits_data  (debug_req_bits_data),
    .debug_resp_valid     (debug_resp_valid),
    .debug_resp_ready     (debug_resp_ready),
    .debug_resp_bits_resp (debug_resp_bits_resp),
    .debug_resp_bits_data (debug_resp_bits_data),
    .dmactive             (dmactive),
    .ndmreset             (ndmreset),
    .haltreq              (haltreq),
    .cmd_start            (cmd_start),
    .cmd_regno            (cmd_regno),
    .cmd_write            (cmd_write),
    .cmd_wdata            (cmd_wdata),
    .cmd_done             (cmd_done),
    .cmd_rdata            (cmd_rdata)
  );

  typedef struct {
    string       name;
    logic [6:0]  addr;
    logic [1:0]  op;
    logic [63:0] wdata;
    logic [1:0]  exp_resp;
    logic [63:0] exp_data;
    logic [2:0]  exp_ctrl;  // {haltreq, ndmreset, dmactive} after the transaction
  } vec_t;

  vec_t vecs[19];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One DMI transaction; optionally pulses cmd_done on the accepting edge.
  task automatic dmi(input logic [6:0] a, input logic [1:0] op, input logic [63:0] d,
                     input bit done_now, input logic [31:0] done_data,
                     output logic [1:0] r, output logic [63:0] rd, output bit started);
    int t;
    @(negedge clk);
    t = 0;
    while (!debug_req_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!debug_req_ready) chk("req_ready_timeout", 64'(debug_req_ready), 64'd1);
    debug_req_valid     = 1'b1;
    debug_req_bits_addr = a;
    debug_req_bits_op   = op;
    debug_req_bits_data = d;
    debug_resp_ready    = 1'b1;
    cmd_done            = done_now;
    cmd_rdata           = done_data;
    @(posedge clk);
    #1;
    debug_req_valid   = 1'b0;
    debug_req_bits_op = 2'd0;
    cmd_done          = 1'b0;
    @(negedge clk);
    t = 0;
    while (!debug_resp_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!debug_resp_valid) chk("resp_valid_timeout", 64'(debug_resp_valid), 64'd1);
    started = cmd_start;
    chk("req_ready_in_resp", 64'(debug_req_ready), 64'd0);
    r  = debug_resp_bits_resp;
    rd = debug_resp_bits_data;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_done(input logic [31:0] d);
    @(negedge clk);
    cmd_done  = 1'b1;
    cmd_rdata = d;
    @(posedge clk);
    #1;
    cmd_done = 1'b0;
  endtask

  // Single-check helpers for the hand-written sequences.
  task automatic rd_chk(input string name, input logic [6:0] a, input logic [63:0] exp);
    logic [1:0] r;
    logic [63:0] rd;
    bit s;
    dmi(a, 2'd1, 64'd0, 1'b0, 32'd0, r, rd, s);
    chk(name, rd, exp);
  endtask

  task automatic wr_start(input string name, input logic [6:0] a, input logic [63:0] d,
                          input bit exp_start);
    logic [1:0] r;
    logic [63:0] rd;
    bit s;
    dmi(a, 2'd2, d, 1'b0, 32'd0, r, rd, s);
    chk(name, 64'(s), 64'(exp_start));
  endtask

  initial begin
    logic [1:0]  r;
    logic [63:0] rd;
    bit          s;
    int          t;

    vecs[0]  = '{"wr_data0",        7'h04, 2'd2, 64'hDEADBEEF,          2'd0, 64'h0,          3'b000};
    vecs[1]  = '{"rd_data0",        7'h04, 2'd1, 64'h0,                 2'd0, 64'hDEADBEEF,   3'b000};
    vecs[2]  = '{"rd_dmstatus",     7'h11, 2'd1, 64'h0,                 2'd0, 64'h82,         3'b000};
    vecs[3]  = '{"rd_abstractcs",   7'h16, 2'd1, 64'h0,                 2'd0, 64'h1,          3'b000};
    vecs[4]  = '{"op3_data0",       7'h04, 2'd3, 64'h1234,              2'd2, 64'h0,          3'b000};
    vecs[5]  = '{"rd_data0_op3",    7'h04, 2'd1, 64'h0,                 2'd0, 64'hDEADBEEF,   3'b000};
    vecs[6]  = '{"nop",             7'h04, 2'd0, 64'h0,                 2'd0, 64'h0,          3'b000};
    vecs[7]  = '{"rd_dmcontrol0",   7'h10, 2'd1, 64'h0,                 2'd0, 64'h0,          3'b000};
    vecs[8]  = '{"wr_dmcontrol",    7'h10, 2'd2, 64'h8000_0003,         2'd0, 64'h0,          3'b111};
    vecs[9]  = '{"rd_dmcontrol1",   7'h10, 2'd1, 64'h0,                 2'd0, 64'h8000_0003,  3'b111};
    vecs[10] = '{"wr_dmcontrol_off",7'h10, 2'd2, 64'h8000_0002,         2'd0, 64'h0,          3'b000};
    vecs[11] = '{"rd_dmcontrol2",   7'h10, 2'd1, 64'h0,                 2'd0, 64'h0,          3'b000};
    vecs[12] = '{"rd_data0_clr",    7'h04, 2'd1, 64'h0,                 2'd0, 64'h0,          3'b000};
    vecs[13] = '{"wr_unmapped",     7'h20, 2'd2, 64'hFFFF,              2'd0, 64'h0,          3'b000};
    vecs[14] = '{"rd_unmapped",     7'h20, 2'd1, 64'h0,                 2'd0, 64'h0,          3'b000};
    vecs[15] = '{"wr_dmactive",     7'h10, 2'd2, 64'h1,                 2'd0, 64'h0,          3'b001};
    vecs[16] = '{"wr_data0_upper",  7'h04, 2'd2, 64'hFFFF_FFFF_0000_0055, 2'd0, 64'h0,        3'b001};
    vecs[17] = '{"rd_data0_55",     7'h04, 2'd1, 64'h0,                 2'd0, 64'h55,         3'b001};
    vecs[18] = '{"rd_command",      7'h17, 2'd1, 64'h0,                 2'd0, 64'h0,          3'b001};

    reset_n             = 1'b0;
    debug_req_valid     = 1'b0;
    debug_req_bits_addr = 7'd0;
    debug_req_bits_op   = 2'd0;
    debug_req_bits_data = '0;
    debug_resp_ready    = 1'b1;
    cmd_done            = 1'b0;
    cmd_rdata           = 32'd0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    chk("rst_req_ready",  64'(debug_req_ready), 64'd1);
    chk("rst_resp_valid", 64'(debug_resp_valid), 64'd0);
    chk("rst_resp_bits",  {62'd0, debug_resp_bits_resp} | debug_resp_bits_data, 64'd0);
    chk("rst_ctrl",       64'({haltreq, ndmreset, dmactive}), 64'd0);
    chk("rst_cmd",        64'({cmd_start, cmd_write, cmd_regno}) | 64'(cmd_wdata), 64'd0);

    // Command while dmactive=0 is ignored.
    wr_start("cmd_inactive_no_start", 7'h17, 64'h0023_1000, 1'b0);

    for (int i = 0; i < 19; i++) begin
      dmi(vecs[i].addr, vecs[i].op, vecs[i].wdata, 1'b0, 32'd0, r, rd, s);
      chk({vecs[i].name, "_resp"}, 64'(r), 64'(vecs[i].exp_resp));
      chk({vecs[i].name, "_data"}, rd, vecs[i].exp_data);
      chk({vecs[i].name, "_ctrl"}, 64'({haltreq, ndmreset, dmactive}), 64'(vecs[i].exp_ctrl));
    end

    // Abstract write command: start pulse and latched fields.
    wr_start("cmdA_start", 7'h17, 64'h0023_1000, 1'b1);
    chk("cmdA_regno", 64'(cmd_regno), 64'h1000);
    chk("cmdA_write", 64'(cmd_write), 64'd1);
    chk("cmdA_wdata", 64'(cmd_wdata), 64'h55);
    rd_chk("cmdA_busy", 7'h16, 64'h1001);
    chk("cmdA_start_one_cycle", 64'(cmd_start), 64'd0);
    pulse_done(32'hAAAA_AAAA);
    rd_chk("cmdA_idle", 7'h16, 64'h1);
    rd_chk("cmdA_data0_kept", 7'h04, 64'h55);

    // Abstract read command with data0 accesses while busy.
    wr_start("cmdB_start", 7'h17, 64'h0022_1001, 1'b1);
    chk("cmdB_write", 64'(cmd_write), 64'd0);
    dmi(7'h04, 2'd2, 64'h99, 1'b0, 32'd0, r, rd, s);
    chk("cmdB_busy_wr_resp", 64'(r), 64'd0);
    rd_chk("cmdB_cmderr1", 7'h16, 64'h1101);
    rd_chk("cmdB_data0_not_overwritten", 7'h04, 64'h55);
    pulse_done(32'h1234_5678);
    rd_chk("cmdB_data0_result", 7'h04, 64'h1234_5678);
    rd_chk("cmdB_abscs_err", 7'h16, 64'h101);
    wr_start("cmdB_w1c", 7'h16, 64'h700, 1'b0);
    rd_chk("cmdB_cmderr_clr", 7'h16, 64'h1);

    // Unsupported command, sticky error, transfer-less command.
    wr_start("cmdC_notsup_no_start", 7'h17, 64'h0100_0000, 1'b0);
    rd_chk("cmdC_cmderr2", 7'h16, 64'h201);
    wr_start("cmdC_sticky_no_start", 7'h17, 64'h0023_1000, 1'b0);
    rd_chk("cmdC_still_err", 7'h16, 64'h201);
    wr_start("cmdC_w1c", 7'h16, 64'h200, 1'b0);
    wr_start("cmdC_notransfer", 7'h17, 64'h0000_1000, 1'b0);
    rd_chk("cmdC_clean", 7'h16, 64'h1);

    // Spurious cmd_done while idle.
    pulse_done(32'hFFFF_0000);
    rd_chk("spurious_done_ignored", 7'h04, 64'h1234_5678);

    // cmd_done on the same edge as a data0 write: request sees busy, result wins.
    wr_start("cmdD_start", 7'h17, 64'h0022_1003, 1'b1);
    dmi(7'h04, 2'd2, 64'hBB, 1'b1, 32'hCAFE, r, rd, s);
    rd_chk("cmdD_collision_abscs", 7'h16, 64'h101);
    rd_chk("cmdD_collision_data0", 7'h04, 64'hCAFE);
    wr_start("cmdD_w1c", 7'h16, 64'h100, 1'b0);

    // Back-pressure with a command in flight, then reset mid-response.
    wr_start("cmdE_start", 7'h17, 64'h0022_1002, 1'b1);
    @(negedge clk);
    debug_req_valid     = 1'b1;
    debug_req_bits_addr = 7'h04;
    debug_req_bits_op   = 2'd1;
    debug_resp_ready    = 1'b0;
    @(posedge clk);
    #1;
    debug_req_bits_addr = 7'h11;  // a second request held pending
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_resp_valid", 64'(debug_resp_valid), 64'd1);
      chk("hold_resp_data", debug_resp_bits_data, 64'hCAFE);
      chk("hold_req_ready", 64'(debug_req_ready), 64'd0);
    end
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_resp_valid", 64'(debug_resp_valid), 64'd0);
    chk("async_rst_req_ready", 64'(debug_req_ready), 64'd1);
    chk("async_rst_dmactive", 64'(dmactive), 64'd0);
    debug_req_valid  = 1'b0;
    debug_resp_ready = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    chk("post_rst_regno", 64'(cmd_regno), 64'd0);
    pulse_done(32'h777);
    rd_chk("post_rst_abscs", 7'h16, 64'h1);
    rd_chk("post_rst_data0", 7'h04, 64'h0);

    t = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dmi_responder.md
Name: dmi_responder

Overview:
- Target (debug-module) end of the DMI request/response channel.
- Accepts 7-bit address / 2-bit op / data requests from a DTM and returns a status code plus read data for each one.
- Implements a minimal register set: data0, dmcontrol, dmstatus, abstractcs and command.
- Forwards abstract register-access commands to the hart side over a start/done handshake.

Parameters:
DATA_WIDTH, 64, DMI data width; registers occupy bits [31:0], upper bits read 0 and are ignored on write (must be >=32)

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous active-low reset
debug_req_valid  input  1  request valid
debug_req_ready  output  1  responder can accept a request
debug_req_bits_addr  input  7  DM register address
debug_req_bits_op  input  2  0 nop, 1 read, 2 write, 3 reserved
debug_req_bits_data  input  DATA_WIDTH  write data
debug_resp_valid  output  1  response valid
debug_resp_ready  input  1  DTM accepts response
debug_resp_bits_resp  output  2  0 success, 2 failed
debug_resp_bits_data  output  DATA_WIDTH  read data
dmactive  output  1  dmcontrol[0]
ndmreset  output  1  dmcontrol[1]
haltreq  output  1  dmcontrol[31]
cmd_start  output  1  one-cycle pulse launching abstract command
cmd_regno  output  16  register number, held from start until done
cmd_write  output  1  1 = write hart register, held with cmd_regno
cmd_wdata  output  32  data0 snapshot at start, held
cmd_done  input  1  one-cycle completion pulse from hart side
cmd_rdata  input  32  read result, valid with cmd_done

Behaviour:
- Reset (reset_n low, async) values:
  - outputs: req_ready=1; resp_valid, resp_bits, dmactive, ndmreset, haltreq, cmd_* all 0.
  - internal: data0=0, cmderr=0, busy=0.
- FSM IDLE/RESP:
  - IDLE: req_ready=1. Request fires when valid & ready; its effect is applied at that edge; next state RESP.
  - RESP: req_ready=0, resp_valid=1. resp/data stay stable until valid & resp_ready, then IDLE.
  - Throughput: one request per 2 cycles minimum. Response appears the cycle after accept.
- Op decode:
  - op=0: resp 0, data 0.
  - op=3: resp 2, data 0, no state change.
  - op=1/2 to an unmapped address: resp 0, reads 0, writes ignored.
- Register map (reads return zero-extended values):
  - 0x04 data0: RW 32 bits.
  - 0x10 dmcontrol: [0] dmactive, [1] ndmreset, [31] haltreq RW; other bits read 0. A write with bit0=0 also clears ndmreset, haltreq, data0 and cmderr. It does not abort an in-flight command.
  - 0x11 dmstatus: RO, constant 0x00000082 (version 2, authenticated).
  - 0x16 abstractcs: [3:0] datacount=1, [10:8] cmderr, [12] busy, [28:24] progbufsize=0. cmderr is W1C per bit; other bits RO.
  - 0x17 command: WO, reads 0. A write is evaluated in priority order:
    1. dmactive=0 → ignored.
    2. busy → cmderr set to 1 if cmderr==0.
    3. cmderr!=0 → ignored.
    4. data[31:24]!=0 → cmderr=2.
    5. data[17] (transfer)=0 → no-op success.
    6. Otherwise: cmd_start=1 for one cycle after the accepting edge; latch regno=data[15:0], write=data[16], wdata=data0; busy=1.
- While busy:
  - Any read or write of data0 sets cmderr=1 if cmderr==0. The data0 write is discarded; a read returns current data0.
  - DMI resp remains 0.
- cmd_done:
  - Ignored when busy=0.
  - Otherwise clears busy; if cmd_write=0, data0 <= cmd_rdata.
  - cmd_done can complete at the earliest the cycle after cmd_start.
- Same-edge collision of cmd_done with a data0 access or command write: the request sees busy=1 (pre-edge state), sets cmderr=1, and the cmd_done update to data0 wins.
- All DMI responses use resp 0 except op=3.
- Reset mid-transaction: everything returns to reset values immediately. A pending response is dropped; an in-flight command is forgotten and a later cmd_done is ignored.

Test Plan:
- Reset, then write 0x04 data 0xDEADBEEF and read 0x04 → resp 0; read data 0x00000000DEADBEEF; req_ready low during each RESP cycle.
- Read 0x11 → 0x82. Read 0x16 → 0x00000001. Op=3 to 0x04 → resp 2, data0 unchanged.
- Set dmcontrol=0x1, data0=0x55, write command 0x00231000 → cmd_start pulse, cmd_regno=0x1000, cmd_write=1, cmd_wdata=0x55. Read 0x16 shows busy=1; after cmd_done, busy=0.
- Command 0x00221001 (read), cmd_done with cmd_rdata=0x12345678 → data0 reads 0x12345678. Write data0 while busy → abstractcs cmderr=1, data0 not overwritten. Write 0x16 with 0x700 → cmderr=0.
- Command 0x01000000 → cmderr=2, no cmd_start. Further command writes are ignored until cmderr is cleared.
- Hold resp_ready=0 for 5 cycles → resp_valid and data stable, no new request accepted. Assert reset_n low mid-RESP → resp_valid=0 and req_ready=1 asynchronously.
